// File: rtl/button_conditioner.sv
// Two-channel push-button front end: synchronises, debounces and arbitrates raw
// button levels into single-cycle press pulses for the lock FSM.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic btn0_raw,
  input  logic btn1_raw,
  input  logic en,
  output logic Button_0_pulse,
  output logic Button_1_pulse,
  output logic conflict_err,
  output logic btn0_level,
  output logic btn1_level
);

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]       raw_s;
  logic [1:0]       sync1_r;
  logic [1:0]       sync2_r;
  logic [1:0]       db_r;
  logic [1:0]       accept_s;
  logic [1:0]       press_s;
  logic [CNT_W-1:0] cnt_r [2];
  logic             pulse0_s;
  logic             pulse1_s;
  logic             err_s;
  logic             pulse0_r;
  logic             pulse1_r;
  logic             err_r;

  assign raw_s = {btn1_raw, btn0_raw};

  // Accept once the synchronised level has disagreed with db for the whole window.
  assign accept_s[0] = (sync2_r[0] != db_r[0]) && (cnt_r[0] == CNT_MAX);
  assign accept_s[1] = (sync2_r[1] != db_r[1]) && (cnt_r[1] == CNT_MAX);
  assign press_s     = accept_s & sync2_r;

  // Synchroniser and debounce state for both channels
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_r <= 2'b00;
      sync2_r <= 2'b00;
      db_r    <= 2'b00;
      for (int n = 0; n < 2; n++) begin
        cnt_r[n] <= CNT_ZERO;
      end
    end else begin
      sync1_r <= raw_s;
      sync2_r <= sync1_r;
      for (int n = 0; n < 2; n++) begin
        if (sync2_r[n] == db_r[n]) begin
          cnt_r[n] <= CNT_ZERO;
        end else if (accept_s[n]) begin
          db_r[n]  <= sync2_r[n];
          cnt_r[n] <= CNT_ZERO;
        end else begin
          cnt_r[n] <= cnt_r[n] + CNT_ONE;
        end
      end
    end
  end

  // Arbitration uses pre-edge db, so a channel releasing this edge still counts as held.
  always_comb begin
    pulse0_s = 1'b0;
    pulse1_s = 1'b0;
    err_s    = 1'b0;
    if (en) begin
      pulse0_s = press_s[0] & ~press_s[1] & ~db_r[1];
      pulse1_s = press_s[1] & ~press_s[0] & ~db_r[0];
      err_s    = (press_s[0] & (press_s[1] | db_r[1])) | (press_s[1] & db_r[0]);
    end else begin
      pulse0_s = 1'b0;
      pulse1_s = 1'b0;
      err_s    = 1'b0;
    end
  end

  // Output pulse registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pulse0_r <= 1'b0;
      pulse1_r <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      pulse0_r <= pulse0_s;
      pulse1_r <= pulse1_s;
      err_r    <= err_s;
    end
  end

  assign Button_0_pulse = pulse0_r;
  assign Button_1_pulse = pulse1_r;
  assign conflict_err   = err_r;
  assign btn0_level     = db_r[0];
  assign btn1_level     = db_r[1];

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner with a 4-cycle debounce window.
module tb_button_conditioner;

  typedef struct {
    int unsigned at;
    logic [4:0]  val;
  } exp_t;

  logic clk;
  logic rst;
  logic btn0_raw;
  logic btn1_raw;
  logic en;
  logic b0_pulse;
  logic b1_pulse;
  logic err;
  logic lvl0;
  logic lvl1;
  logic [4:0] obs;

  int unsigned edge_n = 0;
  int tests_run = 0;
  int tests_failed = 0;
  exp_t exp_q [$];

  button_conditioner #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .btn0_raw(btn0_raw), .btn1_raw(btn1_raw), .en(en),
    .Button_0_pulse(b0_pulse), .Button_1_pulse(b1_pulse), .conflict_err(err),
    .btn0_level(lvl0), .btn1_level(lvl1)
  );

  // obs = {pulse0, pulse1, conflict_err, level0, level1}
  assign obs = {b0_pulse, b1_pulse, err, lvl0, lvl1};

  always #5 clk = ~clk;

  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic test_reset();
    exp_t e;
    repeat (2) @(negedge clk);
    tests_run++;
    if (obs !== 5'b00000) begin
      tests_failed++;
      $display("FAIL reset_state obs=%b exp=00000", obs);
    end
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      tests_run++;
      if (exp_q.size() != 0 && exp_q[0].at == edge_n) begin
        e = exp_q.pop_front();
        if (obs !== e.val) begin
          tests_failed++;
          $display("FAIL reset_pre edge=%0d obs=%b exp=%b", edge_n, obs, e.val);
        end
      end else if (obs[4:2] !== 3'b000) begin
        tests_failed++;
        $display("FAIL reset_pre_idle edge=%0d obs=%b exp=000xx", edge_n, obs);
      end
      if (i == 0) begin
        rst = 1'b1;
        btn0_raw = 1'b1;
        exp_q.push_back('{edge_n + 5, 5'b00000});
        exp_q.push_back('{edge_n + 6, 5'b10010});
      end
      if (i == 15) btn1_raw = 1'b1;
    end
    // asynchronous assertion mid-cycle with both buttons held
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    tests_run++;
    if (obs !== 5'b00000) begin
      tests_failed++;
      $display("FAIL reset_async obs=%b exp=00000", obs);
    end
    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      tests_run++;
      if (exp_q.size() != 0 && exp_q[0].at == edge_n) begin
        e = exp_q.pop_front();
        if (obs !== e.val) begin
          tests_failed++;
          $display("FAIL reset_post edge=%0d obs=%b exp=%b", edge_n, obs, e.val);
        end
      end else if (obs[4:2] !== 3'b000) begin
        tests_failed++;
        $display("FAIL reset_post_idle edge=%0d obs=%b exp=000xx", edge_n, obs);
      end
      if (i == 0) begin
        rst = 1'b1;
        btn1_raw = 1'b0;
        exp_q.push_back('{edge_n + 5, 5'b00000});
        exp_q.push_back('{edge_n + 6, 5'b10010});
      end
      if (i == 10) begin
        btn0_raw = 1'b0;
        exp_q.push_back('{edge_n + 5, 5'b00010});
        exp_q.push_back('{edge_n + 6, 5'b00000});
      end
    end
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL reset_drain pending=%0d exp=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_single_press();
    exp_t e;
    for (int i = 0; i < 31; i++) begin
      @(negedge clk);
      tests_run++;
      if (exp_q.size() != 0 && exp_q[0].at == edge_n) begin
        e = exp_q.pop_front();
        if (obs !== e.val) begin
          tests_failed++;
          $display("FAIL single edge=%0d obs=%b exp=%b", edge_n, obs, e.val);
        end
      end else if (obs[4:2] !== 3'b000) begin
        tests_failed++;
        $display("FAIL single_idle edge=%0d obs=%b exp=000xx", edge_n, obs);
      end
      if (i == 0) begin
        btn1_raw = 1'b1;
        exp_q.push_back('{edge_n + 5, 5'b00000});
        exp_q.push_back('{edge_n + 6, 5'b01001});
      end
      if (i == 20) begin
        btn1_raw = 1'b0;
        exp_q.push_back('{edge_n + 5, 5'b00001});
        exp_q.push_back('{edge_n + 6, 5'b00000});
      end
    end
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL single_drain pending=%0d exp=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_bounce();
    exp_t e;
    logic [4:0] pat = 5'b01101;
    for (int i = 0; i < 33; i++) begin
      @(negedge clk);
      tests_run++;
      if (exp_q.size() != 0 && exp_q[0].at == edge_n) begin
        e = exp_q.pop_front();
        if (obs !== e.val) begin
          tests_failed++;
          $display("FAIL bounce edge=%0d obs=%b exp=%b", edge_n, obs, e.val);
        end
      end else if (obs[4:2] !== 3'b000) begin
        tests_failed++;
        $display("FAIL bounce_idle edge=%0d obs=%b exp=000xx", edge_n, obs);
      end
      if (i == 0) begin
        exp_q.push_back('{edge_n + 10, 5'b00000});
        exp_q.push_back('{edge_n + 11, 5'b10010});
      end
      if (i < 5) btn0_raw = pat[i];
      else if (i < 20) btn0_raw = 1'b1;
      if (i == 20) begin
        btn0_raw = 1'b0;
        exp_q.push_back('{edge_n + 5, 5'b00010});
        exp_q.push_back('{edge_n + 6, 5'b00000});
      end
    end
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL bounce_drain pending=%0d exp=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_simultaneous();
    exp_t e;
    for (int i = 0; i < 23; i++) begin
      @(negedge clk);
      tests_run++;
      if (exp_q.size() != 0 && exp_q[0].at == edge_n) begin
        e = exp_q.pop_front();
        if (obs !== e.val) begin
          tests_failed++;
          $display("FAIL simul edge=%0d obs=%b exp=%b", edge_n, obs, e.val);
        end
      end else if (obs[4:2] !== 3'b000) begin
        tests_failed++;
        $display("FAIL simul_idle edge=%0d obs=%b exp=000xx", edge_n, obs);
      end
      if (i == 0) begin
        btn0_raw = 1'b1;
        btn1_raw = 1'b1;
        exp_q.push_back('{edge_n + 6, 5'b00111});
      end
      if (i == 12) begin
        btn0_raw = 1'b0;
        btn1_raw = 1'b0;
        exp_q.push_back('{edge_n + 6, 5'b00000});
      end
    end
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL simul_drain pending=%0d exp=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_held_conflict();
    exp_t e;
    for (int i = 0; i < 48; i++) begin
      @(negedge clk);
      tests_run++;
      if (exp_q.size() != 0 && exp_q[0].at == edge_n) begin
        e = exp_q.pop_front();
        if (obs !== e.val) begin
          tests_failed++;
          $display("FAIL held edge=%0d obs=%b exp=%b", edge_n, obs, e.val);
        end
      end else if (obs[4:2] !== 3'b000) begin
        tests_failed++;
        $display("FAIL held_idle edge=%0d obs=%b exp=000xx", edge_n, obs);
      end
      case (i)
        0: begin
          btn0_raw = 1'b1;
          exp_q.push_back('{edge_n + 6, 5'b10010});
        end
        10: begin
          btn1_raw = 1'b1;
          exp_q.push_back('{edge_n + 6, 5'b00111});
        end
        20: begin
          btn0_raw = 1'b0;
          btn1_raw = 1'b0;
          exp_q.push_back('{edge_n + 6, 5'b00000});
        end
        30: begin
          btn1_raw = 1'b1;
          exp_q.push_back('{edge_n + 6, 5'b01001});
        end
        38: begin
          btn1_raw = 1'b0;
          exp_q.push_back('{edge_n + 6, 5'b00000});
        end
        default: ;
      endcase
    end
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL held_drain pending=%0d exp=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_enable_sequence();
    exp_t e;
    logic [4:0] seq = 5'b01011;
    for (int i = 0; i < 31 + 5 * 16; i++) begin
      @(negedge clk);
      tests_run++;
      if (exp_q.size() != 0 && exp_q[0].at == edge_n) begin
        e = exp_q.pop_front();
        if (obs !== e.val) begin
          tests_failed++;
          $display("FAIL enable_seq edge=%0d obs=%b exp=%b", edge_n, obs, e.val);
        end
      end else if (obs[4:2] !== 3'b000) begin
        tests_failed++;
        $display("FAIL enable_seq_idle edge=%0d obs=%b exp=000xx", edge_n, obs);
      end
      if (i == 0) begin
        en = 1'b0;
        btn0_raw = 1'b1;
        exp_q.push_back('{edge_n + 6, 5'b00010});
      end
      if (i == 10) en = 1'b1;
      if (i == 18) begin
        btn0_raw = 1'b0;
        exp_q.push_back('{edge_n + 6, 5'b00000});
      end
      if (i >= 31 && ((i - 31) % 16) == 0) begin
        if (seq[(i - 31) / 16]) begin
          btn1_raw = 1'b1;
          exp_q.push_back('{edge_n + 6, 5'b01001});
        end else begin
          btn0_raw = 1'b1;
          exp_q.push_back('{edge_n + 6, 5'b10010});
        end
      end
      if (i >= 31 && ((i - 31) % 16) == 8) begin
        btn0_raw = 1'b0;
        btn1_raw = 1'b0;
        exp_q.push_back('{edge_n + 6, 5'b00000});
      end
    end
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL enable_seq_drain pending=%0d exp=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    clk = 1'b0;
    rst = 1'b0;
    btn0_raw = 1'b0;
    btn1_raw = 1'b0;
    en = 1'b1;
    test_reset();
    test_single_press();
    test_bounce();
    test_simultaneous();
    test_held_conflict();
    test_enable_sequence();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
